// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared types and flag indices for the condition/flags unit
package cond_pkg;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  typedef enum logic [1:0] {B, BCOND, CBZ, CBNZ} br_kind_e;

  typedef enum logic {IDLE, WAIT} state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code check against an NZCV value
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_nzcv[FLAG_N];
  assign w_z = i_nzcv[FLAG_Z];
  assign w_c = i_nzcv[FLAG_C];
  assign w_v = i_nzcv[FLAG_V];

  always_comb begin
    o_pass = 1'b1;
    case (cond_e'(i_cond))
      EQ:      o_pass = w_z;
      NE:      o_pass = !w_z;
      CS:      o_pass = w_c;
      CC:      o_pass = !w_c;
      MI:      o_pass = w_n;
      PL:      o_pass = !w_n;
      VS:      o_pass = w_v;
      VC:      o_pass = !w_v;
      HI:      o_pass = w_c & !w_z;
      LS:      o_pass = !w_c | w_z;
      GE:      o_pass = (w_n == w_v);
      LT:      o_pass = (w_n != w_v);
      GT:      o_pass = !w_z & (w_n == w_v);
      LE:      o_pass = w_z | (w_n != w_v);
      default: o_pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flags_unit.sv
// rtl/cond_flags_unit.sv - NZCV flag register and branch resolver with flag bypass/stall
module cond_flags_unit
  import cond_pkg::*;
#(
  parameter int NFLAGS = 4,
  parameter int CONDW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alu_valid,
  input  logic              i_alu_set_flags,
  input  logic              i_alu_negative,
  input  logic              i_alu_zero,
  input  logic              i_alu_carry_out,
  input  logic              i_alu_overflow,
  input  logic              i_ex_flag_pending,
  input  logic              i_br_valid,
  input  logic [1:0]        i_br_kind,
  input  logic [CONDW-1:0]  i_br_cond,
  input  logic              i_br_rt_zero,
  input  logic              i_flush,
  output logic [NFLAGS-1:0] o_flags_q,
  output logic              o_br_resolved,
  output logic              o_br_taken,
  output logic              o_br_stall
);

  logic [NFLAGS-1:0] r_flags;
  state_e            r_state;
  logic              r_br_resolved;
  logic              r_br_taken;

  logic [NFLAGS-1:0] w_alu_nzcv;
  logic [NFLAGS-1:0] w_eff;
  logic              w_alu_fw;
  logic              w_pass;
  logic              w_outcome;
  logic              w_is_bcond;
  logic              w_br_go;
  logic              w_idle_resolve;
  logic              w_to_wait;
  logic              w_wait_resolve;
  logic              w_resolve;

  assign w_alu_nzcv = {i_alu_negative, i_alu_zero, i_alu_carry_out, i_alu_overflow};
  assign w_alu_fw   = i_alu_valid & i_alu_set_flags;
  assign w_eff      = w_alu_fw ? w_alu_nzcv : r_flags;

  cond_eval u_cond_eval (
    .i_cond (i_br_cond),
    .i_nzcv (w_eff),
    .o_pass (w_pass)
  );

  always_comb begin
    w_outcome = 1'b0;
    case (br_kind_e'(i_br_kind))
      B:       w_outcome = 1'b1;
      BCOND:   w_outcome = w_pass;
      CBZ:     w_outcome = i_br_rt_zero;
      CBNZ:    w_outcome = !i_br_rt_zero;
      default: w_outcome = 1'b0;
    endcase
  end

  // Only B.cond depends on flags, so only it can be held waiting for a pending flag write.
  assign w_is_bcond     = (br_kind_e'(i_br_kind) == BCOND);
  assign w_br_go        = i_br_valid & !i_flush;
  assign w_idle_resolve = (r_state == IDLE) & w_br_go &
                          (!w_is_bcond | !i_ex_flag_pending | w_alu_fw);
  assign w_to_wait      = (r_state == IDLE) & w_br_go & w_is_bcond &
                          i_ex_flag_pending & !w_alu_fw;
  assign w_wait_resolve = (r_state == WAIT) & w_alu_fw & !i_flush;
  assign w_resolve      = w_idle_resolve | w_wait_resolve;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags       <= '0;
      r_state       <= IDLE;
      r_br_resolved <= 1'b0;
      r_br_taken    <= 1'b0;
    end else begin
      if (w_alu_fw && !i_flush) begin
        r_flags <= w_alu_nzcv;
      end
      case (r_state)
        IDLE:    if (w_to_wait) r_state <= WAIT;
        WAIT:    if (w_wait_resolve || i_flush) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      r_br_resolved <= w_resolve;
      r_br_taken    <= w_resolve & w_outcome;
    end
  end

  assign o_flags_q     = r_flags;
  assign o_br_resolved = r_br_resolved;
  assign o_br_taken    = r_br_taken;
  // Reset also masks the combinational stall so a held branch cannot stall during reset.
  assign o_br_stall    = rst_n & (w_to_wait | ((r_state == WAIT) & !w_wait_resolve));

endmodule

// File: tb/tb_cond_flags_unit.sv
// tb/tb_cond_flags_unit.sv - self-checking bench for cond_flags_unit
module tb_cond_flags_unit;
  import cond_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_valid, alu_set_flags, alu_n, alu_z, alu_c, alu_v;
  logic       ex_flag_pending, br_valid, br_rt_zero, flush;
  logic [1:0] br_kind;
  logic [3:0] br_cond;
  logic [3:0] flags_q;
  logic       br_resolved, br_taken, br_stall;

  int n_pass  = 0;
  int n_total = 0;
  logic exp_q[$];

  typedef struct {
    logic [1:0] kind;
    logic [3:0] cond;
    logic [3:0] nzcv;
    logic       rt_zero;
    logic       pending;
    logic       use_alu;
    logic       exp_stall;
    logic       exp_taken;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cond_flags_unit #(.NFLAGS(4), .CONDW(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_alu_valid       (alu_valid),
    .i_alu_set_flags   (alu_set_flags),
    .i_alu_negative    (alu_n),
    .i_alu_zero        (alu_z),
    .i_alu_carry_out   (alu_c),
    .i_alu_overflow    (alu_v),
    .i_ex_flag_pending (ex_flag_pending),
    .i_br_valid        (br_valid),
    .i_br_kind         (br_kind),
    .i_br_cond         (br_cond),
    .i_br_rt_zero      (br_rt_zero),
    .i_flush           (flush),
    .o_flags_q         (flags_q),
    .o_br_resolved     (br_resolved),
    .o_br_taken        (br_taken),
    .o_br_stall        (br_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic drive(input logic bv, input logic [1:0] kind, input logic [3:0] cond,
                       input logic rtz, input logic pend, input logic av, input logic sf,
                       input logic [3:0] nzcv, input logic fl);
    br_valid = bv; br_kind = kind; br_cond = cond; br_rt_zero = rtz;
    ex_flag_pending = pend; alu_valid = av; alu_set_flags = sf;
    {alu_n, alu_z, alu_c, alu_v} = nzcv; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic write_flags(input logic [3:0] nzcv);
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, nzcv, 1'b0);
  endtask

  // Every resolve pulse must match the oldest expected outcome; any other pulse is spurious.
  always @(posedge clk) begin
    #1;
    if (br_resolved) begin
      if (exp_q.size() == 0) chk("spurious_resolve", 32'(br_resolved), 32'd0);
      else chk("br_taken", 32'(br_taken), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++)
        vecs.push_back('{BCOND, 4'(c), 4'(f), 1'b0, 1'b0, 1'b1, 1'b0, ref_pass(4'(c), 4'(f))});
    vecs.push_back('{B,     4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{CBZ,   4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{CBNZ,  4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{CBZ,   4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{CBNZ,  4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{BCOND, 4'h0, 4'h4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});

    idle();
    #1;
    chk("reset_flags", 32'(flags_q), 32'd0);
    chk("reset_resolved", 32'(br_resolved), 32'd0);
    chk("reset_taken", 32'(br_taken), 32'd0);
    chk("reset_stall", 32'(br_stall), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // SUBS equal operands, then EQ / NE back to back
    @(negedge clk); write_flags(4'b0110);
    @(negedge clk); drive(1'b1, BCOND, EQ, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0); exp_q.push_back(1'b1);
    #1 chk("subs_flags", 32'(flags_q), 32'b0110);
    @(negedge clk); drive(1'b1, BCOND, NE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0); exp_q.push_back(1'b0);
    @(negedge clk); idle();

    // same-cycle bypass: LT and GE with flags_q = 0000, incoming 1000
    @(negedge clk); write_flags(4'b0000);
    @(negedge clk); drive(1'b1, BCOND, LT, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0); exp_q.push_back(1'b1);
    #1 chk("bypass_stall", 32'(br_stall), 32'd0);
    @(negedge clk); write_flags(4'b0000);
    @(negedge clk); drive(1'b1, BCOND, GE, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0); exp_q.push_back(1'b0);
    @(negedge clk); idle();
    #1 chk("bypass_flags", 32'(flags_q), 32'b1000);

    // stall three cycles, flags arrive on the fourth
    @(negedge clk); drive(1'b1, BCOND, GT, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    #1 chk("stall_c1", 32'(br_stall), 32'd1);
    @(negedge clk); #1 chk("stall_c2", 32'(br_stall), 32'd1);
    @(negedge clk); #1 chk("stall_c3", 32'(br_stall), 32'd1);
    @(negedge clk); drive(1'b1, BCOND, GT, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0); exp_q.push_back(1'b1);
    #1 chk("stall_release", 32'(br_stall), 32'd0);
    @(negedge clk); idle();
    #1 chk("stall_after", 32'(br_stall), 32'd0);
    chk("stall_flags", 32'(flags_q), 32'b0000);

    // flush while waiting, with a flushed SUBS in the same cycle
    @(negedge clk); write_flags(4'b0101);
    @(negedge clk); drive(1'b1, BCOND, EQ, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    #1 chk("flush_enter_wait", 32'(br_stall), 32'd1);
    @(negedge clk); drive(1'b1, BCOND, EQ, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
    @(negedge clk); idle();
    #1 chk("flush_stall", 32'(br_stall), 32'd0);
    chk("flush_flags_kept", 32'(flags_q), 32'b0101);
    @(negedge clk); write_flags(4'b0011);
    #1 chk("flush_idle_stall", 32'(br_stall), 32'd0);
    @(negedge clk); idle();
    #1 chk("post_flush_flags", 32'(flags_q), 32'b0011);

    // async reset while waiting
    @(negedge clk); write_flags(4'b1111);
    @(negedge clk); drive(1'b1, BCOND, NE, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    #1 chk("areset_pre_flags", 32'(flags_q), 32'b1111);
    chk("areset_pre_stall", 32'(br_stall), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("areset_flags", 32'(flags_q), 32'd0);
    chk("areset_stall", 32'(br_stall), 32'd0);
    chk("areset_resolved", 32'(br_resolved), 32'd0);
    idle();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); write_flags(4'b0100);
    #1 chk("areset_idle_stall", 32'(br_stall), 32'd0);
    @(negedge clk); idle();
    repeat (2) @(negedge clk);

    // table: full condition x NZCV sweep via bypass, plus non-flag branch kinds
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].kind, vecs[i].cond, vecs[i].rt_zero, vecs[i].pending,
            vecs[i].use_alu, vecs[i].use_alu, vecs[i].nzcv, 1'b0);
      if (!vecs[i].exp_stall) exp_q.push_back(vecs[i].exp_taken);
      #1 chk($sformatf("vec%0d_stall", i), 32'(br_stall), 32'(vecs[i].exp_stall));
    end
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cond_flags_unit.md
Name: cond_flags_unit

Overview:
- Consumer end of the ALU flag interface: it receives negative/zero/carry_out/overflow from the adder-subtractor datapath.
- Holds the architectural NZCV flag register and resolves conditional branches (B.cond, CBZ/CBNZ, B) for the pipelined ARM CPU.
- Handles the flag-setting hazard in one of two ways: it forwards same-cycle flags, or it stalls the branch until the flags arrive.
- Sits between EX (flag producer) and the fetch redirect logic.

Parameters:
- NFLAGS, 4, number of flag bits (N, Z, C, V order, MSB = N).
- CONDW, 4, width of the ARM condition field.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- alu_valid  input  1  EX stage holds a valid, non-flushed instruction.
- alu_set_flags  input  1  that instruction writes NZCV (ADDS/SUBS).
- alu_negative  input  1  N flag from the adder-subtractor.
- alu_zero  input  1  Z flag.
- alu_carry_out  input  1  C flag.
- alu_overflow  input  1  V flag.
- ex_flag_pending  input  1  a flag-setting op is in flight ahead of EX and its flags are not yet on alu_*.
- br_valid  input  1  a branch is presented for resolution.
- br_kind  input  2  00 B, 01 B.cond, 10 CBZ, 11 CBNZ.
- br_cond  input  CONDW  condition field; meaningful for B.cond only.
- br_rt_zero  input  1  the tested register equals zero (CBZ/CBNZ).
- flush  input  1  kill the in-flight branch; also kills the same-cycle flag write.
- flags_q  output  NFLAGS  architectural NZCV.
- br_resolved  output  1  one-cycle pulse: the branch outcome is valid.
- br_taken  output  1  outcome; qualified by br_resolved.
- br_stall  output  1  hold the branch in its stage.

Behaviour:
- Reset (async, rst_n = 0): flags_q = 4'b0000, br_resolved = 0, br_taken = 0, br_stall = 0, FSM = IDLE. Releasing reset mid-WAIT returns the FSM to IDLE.
- Flag write: on a clk edge, if alu_valid & alu_set_flags & !flush, then flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}. Otherwise flags_q holds.
- Effective flags:
  - eff = incoming alu flags when alu_valid & alu_set_flags (bypass).
  - eff = flags_q otherwise.
- Condition evaluation, combinational on eff:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C & !Z. 9 LS: !C | Z.
  - A GE: N == V. B LT: N != V.
  - C GT: !Z & (N == V). D LE: Z | (N != V).
  - E AL: 1. F NV: 1.
- Outcomes by br_kind:
  - B: always taken.
  - CBZ: taken = br_rt_zero. CBNZ: taken = !br_rt_zero.
  - CBZ, CBNZ and B never stall.
- FSM:
  - IDLE:
    - br_valid & !flush & (kind != B.cond | !ex_flag_pending | (alu_valid & alu_set_flags)) -> resolve. br_resolved = 1 and br_taken = outcome on the next cycle (latency 1, registered). Stay in IDLE.
    - br_valid & !flush & kind == B.cond & ex_flag_pending & !(alu_valid & alu_set_flags) -> go to WAIT. br_stall = 1 combinationally in the same cycle.
  - WAIT:
    - br_stall = 1.
    - alu_valid & alu_set_flags & !flush -> resolve with the bypassed flags. br_stall = 0 in that cycle. Go to IDLE.
    - flush -> IDLE with no resolve.
    - Otherwise stay in WAIT.
- flush in any state: no br_resolved pulse on the next cycle; br_taken <= 0.
- br_resolved is a single-cycle pulse. Back-to-back branches in IDLE produce consecutive pulses.
- br_cond and br_kind are held stable by the upstream stage while br_stall = 1.

Decomposition:
- Package cond_pkg holds:
  - typedef enum cond_e (EQ..NV, 4-bit).
  - typedef enum br_kind_e (B, BCOND, CBZ, CBNZ).
  - Flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - typedef enum state_e (IDLE, WAIT).
- Sub-module cond_eval: purely combinational (cond, nzcv) -> pass. Instantiated once on eff.

Test Plan:
- Reset then SUBS equal operands: alu flags N0 Z1 C1 V0 with set_flags -> flags_q = 4'b0110 next cycle. Then B.cond EQ -> br_resolved = 1, br_taken = 1. B.cond NE -> br_taken = 0.
- Bypass: in the same cycle, SUBS with flags 4'b1000 and B.cond LT (0xB) with flags_q = 0000 -> br_taken = 1, since the bypass uses N = 1, V = 0. Same setup with GE -> br_taken = 0.
- Stall: ex_flag_pending = 1, B.cond GT, no alu flags for 3 cycles -> br_stall high for 3 cycles and no br_resolved. On cycle 4, flags 4'b0000 arrive -> br_stall drops and br_taken = 1 on the next cycle.
- Flush in WAIT: enter WAIT, assert flush -> FSM to IDLE, no br_resolved pulse, br_stall = 0. A flushed SUBS in the same cycle leaves flags_q unchanged.
- CBZ/CBNZ and B with ex_flag_pending = 1 -> no stall. CBZ with rt_zero = 1 -> taken. CBNZ with rt_zero = 1 -> not taken. B -> taken.
- Async reset asserted mid-WAIT with flags_q = 4'b1111 -> immediately flags_q = 0, br_stall = 0, and no resolve after release. Sweep all 16 conditions against all 16 NZCV values versus a reference model.
